thread_scheduler: RTL
=====================

# thread_scheduler

Issue scheduler for the barrel-threaded core: each cycle it picks one hardware thread to issue into fetch and drives the thread id that selects the active register-file bank. It tracks per-thread run state (idle, running, waiting on a multi-cycle stall) and arbitrates round-robin among eligible threads. It replaces free-running thread rotation with a stall-aware issue handshake toward the fetch stage.

## Interface

Parameters:
- NUM_THREADS, 4, number of hardware threads / register-file banks (power of two, ≥2)
- TID_W, $clog2(NUM_THREADS), thread id width
- CNT_W, 4, stall-length counter width
- BOOT_MASK, 'b0001, threads in RUN immediately after reset (bit i = thread i)

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- thread_start  input  NUM_THREADS  per-thread pulse, IDLE→RUN
- thread_halt  input  NUM_THREADS  per-thread pulse, any state→IDLE
- stall_valid  input  1  stall request strobe
- stall_tid  input  TID_W  thread to stall
- stall_cycles  input  CNT_W  number of cycles the thread is ineligible
- issue_ready  input  1  fetch accepts the offered thread this cycle
- issue_valid  output  1  a thread is offered
- issue_tid  output  TID_W  offered thread id / register-file bank select
- issue_onehot  output  NUM_THREADS  one-hot of issue_tid, all-zero when !issue_valid
- thread_active  output  NUM_THREADS  bit i = thread i not IDLE

## Operation

- Per-thread FSM: IDLE, RUN, WAIT. Eligible = RUN only.
- IDLE→RUN on thread_start[i]; start in RUN/WAIT ignored.
- RUN/WAIT→WAIT on stall_valid with stall_tid=i and stall_cycles≠0: counter loaded with stall_cycles (reload overwrites a pending count). stall_cycles=0 or stall on IDLE thread: no effect.
- WAIT: counter decrements every cycle; at count 1 the thread returns to RUN on the next edge.
- Any state→IDLE on thread_halt[i]; counter cleared.
- Same-cycle priority for one thread: halt > stall > start.
- Arbitration: registered pointer ptr = last granted tid. Candidate = first eligible thread searching ptr+1, ptr+2, … with wrap modulo NUM_THREADS (ptr itself checked last). On issue_valid && issue_ready, ptr ← issue_tid.
- issue_valid = any thread eligible. When !issue_valid, issue_tid = 0.
- A thread stalled or halted in the cycle it is granted is still granted that cycle; the state change takes effect next cycle.

## Timing

- issue_valid/issue_tid/issue_onehot are combinational from registered state and ptr; zero-latency offer, no input→output path from thread_start/stall/halt (those affect eligibility from the next cycle).
- issue_ready is used only for the ptr update; offer may change while !issue_ready only if eligibility changes.
- stall at cycle N with stall_cycles=K: thread ineligible cycles N+1..N+K, eligible again at N+K+1.
- thread_start at cycle N: eligible from N+1.
- Reset values: threads in BOOT_MASK → RUN, others IDLE; all counters 0; ptr = NUM_THREADS-1 (thread 0 searched first); thread_active = BOOT_MASK; issue_valid = (BOOT_MASK≠0), issue_tid = lowest set bit of BOOT_MASK.
- rst asserted mid-operation overrides every other input that cycle.

## Configuration

- THREAD_SCHED_SKIP_EN defined: round-robin with skipping as described above; non-eligible threads never waste an issue slot.
- Not defined: fixed-slot barrel mode. ptr becomes a free-running slot counter, incremented every cycle (wraps at NUM_THREADS) independent of issue_ready; issue_tid = slot, issue_valid = slot thread eligible. Reset slot = 0. Per-thread FSM unchanged.

## Test plan

- Reset with BOOT_MASK='b0001, issue_ready=1: issue_tid=0 every cycle, thread_active='b0001.
- Start threads 1,2,3 at cycle 2, issue_ready=1: from cycle 3 issue_tid sequence 1,2,3,0,1… .
- All four running, stall thread 2 with stall_cycles=3 at cycle N: thread 2 absent N+1..N+3, offered again from N+4; (SKIP_EN) no invalid slots; (no SKIP_EN) issue_valid=0 in thread 2's slots only.
- issue_ready held 0 for 5 cycles with all running: issue_tid constant, ptr unchanged; on ready=1 rotation resumes from next thread.
- Same cycle halt+stall+start on thread 1 (RUN): thread 1 → IDLE, thread_active[1]=0; stall_cycles=0 on thread 3: no change.
- Assert rst while thread 2 in WAIT: next cycle state equals reset values, thread 2 IDLE, counter 0.

Source files
------------

// File: rtl/thread_scheduler.sv
// Barrel-thread issue scheduler: per-thread IDLE/RUN/WAIT state plus issue arbitration.
// Define THREAD_SCHED_SKIP_EN for skipping round-robin; default is fixed-slot barrel mode.
module thread_scheduler #(
  parameter int NUM_THREADS = 4,
  parameter int TID_W = $clog2(NUM_THREADS),
  parameter int CNT_W = 4,
  parameter logic [NUM_THREADS-1:0] BOOT_MASK = 'b0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] thread_start,
  input  logic [NUM_THREADS-1:0] thread_halt,
  input  logic                   stall_valid,
  input  logic [TID_W-1:0]       stall_tid,
  input  logic [CNT_W-1:0]       stall_cycles,
  input  logic                   issue_ready,
  output logic                   issue_valid,
  output logic [TID_W-1:0]       issue_tid,
  output logic [NUM_THREADS-1:0] issue_onehot,
  output logic [NUM_THREADS-1:0] thread_active
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT
  } st_t;

  st_t              r_st  [NUM_THREADS];
  logic [CNT_W-1:0] r_cnt [NUM_THREADS];
  logic [TID_W-1:0] r_ptr;

  logic [NUM_THREADS-1:0] w_elig;
  logic [NUM_THREADS-1:0] w_stall;
  logic                   w_valid;
  logic [TID_W-1:0]       w_tid;

  always_comb begin
    w_elig = '0;
    w_stall = '0;
    thread_active = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_elig[i] = (r_st[i] == ST_RUN);
      thread_active[i] = (r_st[i] != ST_IDLE);
      w_stall[i] = stall_valid
                && (stall_tid == TID_W'(i))
                && (stall_cycles != '0);
    end
  end

`ifdef THREAD_SCHED_SKIP_EN
  logic [TID_W-1:0] w_idx;

  // k wraps to 0 at NUM_THREADS, so ptr itself is checked last
  always_comb begin
    w_valid = 1'b0;
    w_tid = '0;
    w_idx = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      w_idx = r_ptr + TID_W'(k);
      if (!w_valid && w_elig[w_idx]) begin
        w_valid = 1'b1;
        w_tid = w_idx;
      end
    end
  end
`else
  logic w_unused_ready;
  assign w_unused_ready = issue_ready;

  always_comb begin
    w_valid = w_elig[r_ptr];
    w_tid = w_valid ? r_ptr : '0;
  end
`endif

  always_comb begin
    issue_onehot = '0;
    if (w_valid) issue_onehot[w_tid] = 1'b1;
  end

  assign issue_valid = w_valid;
  assign issue_tid = w_tid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_st[i] <= BOOT_MASK[i] ? ST_RUN : ST_IDLE;
        r_cnt[i] <= '0;
      end
`ifdef THREAD_SCHED_SKIP_EN
      r_ptr <= TID_W'(NUM_THREADS - 1);
`else
      r_ptr <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (thread_halt[i]) begin
          r_st[i] <= ST_IDLE;
          r_cnt[i] <= '0;
        end else if (w_stall[i] && r_st[i] != ST_IDLE) begin
          r_st[i] <= ST_WAIT;
          r_cnt[i] <= stall_cycles;
        end else if (thread_start[i] && r_st[i] == ST_IDLE) begin
          r_st[i] <= ST_RUN;
        end else if (r_st[i] == ST_WAIT) begin
          if (r_cnt[i] == CNT_W'(1)) begin
            r_st[i] <= ST_RUN;
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          end
        end
      end
`ifdef THREAD_SCHED_SKIP_EN
      if (w_valid && issue_ready) r_ptr <= w_tid;
`else
      r_ptr <= r_ptr + TID_W'(1);
`endif
    end
  end

endmodule
